// File: rtl/shift_pkg.sv
// Shared types and the single-bit step function for param_shift_engine.
// The step function works on a MAX_W-wide value with the active width given
// by its MSB index, so one definition serves any WIDTH up to MAX_W.
package shift_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = 6;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_INV  = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic [MAX_W-1:0] q;
    logic             out_bit;
  } step_t;

  // Shift and rotate opcodes take an amount and may run for several cycles.
  function automatic logic is_step_op(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

  // One step of op on q. Bits of q above msb must be zero on entry; bits of
  // the result above msb are don't-care and are dropped by the caller.
  function automatic step_t step_fn(input op_e              op,
                                    input logic [MAX_W-1:0] q,
                                    input logic             ser_in,
                                    input logic [IDX_W-1:0] msb);
    step_t r;
    r.q       = q;
    r.out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        r.q       = {q[MAX_W-2:0], ser_in};
        r.out_bit = q[msb];
      end
      OP_SHR: begin
        r.q       = q >> 1;
        r.q[msb]  = ser_in;
        r.out_bit = q[0];
      end
      OP_ROL: begin
        r.q       = {q[MAX_W-2:0], q[msb]};
        r.out_bit = q[msb];
      end
      OP_ROR: begin
        r.q       = q >> 1;
        r.q[msb]  = q[0];
        r.out_bit = q[0];
      end
      OP_ASR: begin
        r.q       = q >> 1;
        r.q[msb]  = q[msb];
        r.out_bit = q[0];
      end
      OP_INV: begin
        r.q = ~q;
      end
      default: begin
        r.q = q;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/param_shift_engine.sv
// WIDTH-bit shift/rotate register with multi-step sequencing.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | ready; single-cycle ops complete at the accept edge
//   S_SHIFT | running a latched shift/rotate, one bit per edge, rem_q left
//
// WIDTH must be in 2..64 (limited by the shared step function).
module param_shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] MSB = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;

  op_e              op_in;
  op_e              step_op;
  step_t            step_res;

  assign op_in = op_e'(op);

  // While shifting the latched op drives the step; in IDLE the incoming op
  // does, which is how INV shares the same datapath.
  assign step_op  = (state_q == S_SHIFT) ? op_q : op_in;
  assign step_res = step_fn(step_op, MAX_W'(data_q), ser_in, MSB);

  // Result bits above WIDTH are intentionally discarded.
  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^step_res.q[MAX_W-1:WIDTH];
  end

  // State, counter and register updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      rem_q     <= '0;
      data_q    <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
    end
  end

  // Next-state: accept in IDLE, one step per edge in SHIFT.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    data_d    = data_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (is_step_op(op_in) && (amount != '0)) begin
            state_d = S_SHIFT;
            op_d    = op_in;
            rem_d   = amount;
          end else begin
            // NOP, LOAD, INV and zero-amount shifts finish at the accept edge.
            done_d = 1'b1;
            case (op_in)
              OP_LOAD: data_d = data_in;
              OP_INV:  data_d = step_res.q[WIDTH-1:0];
              default: data_d = data_q;
            endcase
          end
        end
      end
      S_SHIFT: begin
        data_d    = step_res.q[WIDTH-1:0];
        ser_out_d = step_res.out_bit;
        rem_d     = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == S_SHIFT);
  assign op_ready = ~busy;
  assign q        = data_q;
  assign ser_out  = ser_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// Directed bench for param_shift_engine at WIDTH=8.
module tb_param_shift_engine;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] SHR  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] ASR  = 3'b110;
  localparam logic [2:0] INV  = 3'b111;

  logic             clk;
  logic             reset_n;
  logic [2:0]       op;
  logic [CNT_W-1:0] amount;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] data_in;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  int n_checks;
  int n_pass;

  param_shift_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .amount   (amount),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .data_in  (data_in),
    .ser_in   (ser_in),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op for one edge, then withdraw it; returns #1 after the edge.
  task automatic issue(input logic [2:0] o, input logic [CNT_W-1:0] a,
                       input logic [WIDTH-1:0] d);
    op       = o;
    amount   = a;
    data_in  = d;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // Count edges while busy, bounded by max_cycles.
  task automatic run_busy(input int max_cycles, output int cycles);
    cycles = 0;
    while (busy && cycles < max_cycles) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (q !== 8'h00) $display("FAIL reset_q got=%h exp=00", q); else n_pass++;
    n_checks++; if ({ser_out, busy, done, op_ready} !== 4'b0001)
      $display("FAIL reset_status got=%b exp=0001", {ser_out, busy, done, op_ready}); else n_pass++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    issue(LOAD, 4'd0, 8'hA5);
    n_checks++; if (q !== 8'hA5) $display("FAIL load_q got=%h exp=a5", q); else n_pass++;
    n_checks++; if ({busy, done} !== 2'b01) $display("FAIL load_done got=%b exp=01", {busy, done}); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL load_done_end got=%b exp=00", {busy, done}); else n_pass++;
  endtask

  task automatic test_shl();
    int cyc;
    ser_in = 1'b1;
    issue(SHL, 4'd3, 8'h00);
    n_checks++; if ({busy, op_ready, done} !== 3'b100)
      $display("FAIL shl_start got=%b exp=100", {busy, op_ready, done}); else n_pass++;
    run_busy(20, cyc);
    n_checks++; if (cyc !== 3) $display("FAIL shl_cycles got=%0d exp=3", cyc); else n_pass++;
    n_checks++; if (q !== 8'h2F) $display("FAIL shl_q got=%h exp=2f", q); else n_pass++;
    n_checks++; if ({ser_out, done} !== 2'b11) $display("FAIL shl_out_done got=%b exp=11", {ser_out, done}); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL shl_done_pulse got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_asr_inv();
    int cyc;
    ser_in = 1'b1;
    issue(LOAD, 4'd0, 8'h90);
    issue(ASR, 4'd2, 8'h00);
    run_busy(20, cyc);
    n_checks++; if (cyc !== 2) $display("FAIL asr_cycles got=%0d exp=2", cyc); else n_pass++;
    n_checks++; if (q !== 8'hE4) $display("FAIL asr_q got=%h exp=e4", q); else n_pass++;
    n_checks++; if (ser_out !== 1'b0) $display("FAIL asr_ser_out got=%b exp=0", ser_out); else n_pass++;
    issue(INV, 4'd0, 8'h00);
    n_checks++; if (q !== 8'h1B) $display("FAIL inv_q got=%h exp=1b", q); else n_pass++;
    n_checks++; if ({ser_out, busy, done} !== 3'b001)
      $display("FAIL inv_status got=%b exp=001", {ser_out, busy, done}); else n_pass++;
  endtask

  task automatic test_ror_ignore();
    int cyc;
    issue(LOAD, 4'd0, 8'h01);
    issue(ROR, 4'd9, 8'h00);
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++; if (op_ready !== 1'b0) $display("FAIL ror_ready_mid got=%b exp=0", op_ready); else n_pass++;
    issue(LOAD, 4'd0, 8'hFF);
    cyc++;
    while (busy && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++; if (cyc !== 9) $display("FAIL ror_cycles got=%0d exp=9", cyc); else n_pass++;
    n_checks++; if (q !== 8'h80) $display("FAIL ror_q got=%h exp=80", q); else n_pass++;
    n_checks++; if ({ser_out, done} !== 2'b11) $display("FAIL ror_out_done got=%b exp=11", {ser_out, done}); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if ({busy, done, q} !== {2'b00, 8'h80})
      $display("FAIL ror_after got=%b_%b_%h exp=0_0_80", busy, done, q); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int seen_done;
    ser_in = 1'b0;
    issue(LOAD, 4'd0, 8'hFF);
    issue(SHR, 4'd5, 8'h00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++; if (q !== 8'h3F) $display("FAIL shr_two_steps got=%h exp=3f", q); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({q, ser_out, busy, done} !== {8'h00, 3'b000})
      $display("FAIL abort_state got=%h_%b%b%b exp=00_000", q, ser_out, busy, done); else n_pass++;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    n_checks++; if (seen_done !== 0) $display("FAIL abort_no_done got=%0d exp=0", seen_done); else n_pass++;
    issue(LOAD, 4'd0, 8'h3C);
    n_checks++; if ({q, done} !== {8'h3C, 1'b1})
      $display("FAIL post_reset_load got=%h_%b exp=3c_1", q, done); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_amount();
    int cyc;
    ser_in = 1'b1;
    issue(SHL, 4'd0, 8'h00);
    n_checks++; if ({q, busy, done} !== {8'h3C, 2'b01})
      $display("FAIL shl0 got=%h_%b%b exp=3c_01", q, busy, done); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL shl0_pulse got=%b exp=00", {busy, done}); else n_pass++;
    issue(ROL, 4'd1, 8'h00);
    run_busy(10, cyc);
    n_checks++; if (cyc !== 1) $display("FAIL rol1_cycles got=%0d exp=1", cyc); else n_pass++;
    n_checks++; if ({q, ser_out, done} !== {8'h78, 2'b01})
      $display("FAIL rol1 got=%h_%b%b exp=78_01", q, ser_out, done); else n_pass++;
    // Accept during the done cycle.
    n_checks++; if (op_ready !== 1'b1) $display("FAIL ready_on_done got=%b exp=1", op_ready); else n_pass++;
    issue(LOAD, 4'd0, 8'h0F);
    n_checks++; if ({q, done} !== {8'h0F, 1'b1})
      $display("FAIL load_on_done got=%h_%b exp=0f_1", q, done); else n_pass++;
  endtask

  task automatic test_long_shift();
    int cyc;
    ser_in = 1'b1;
    issue(SHR, 4'd10, 8'h00);
    run_busy(30, cyc);
    n_checks++; if (cyc !== 10) $display("FAIL shr10_cycles got=%0d exp=10", cyc); else n_pass++;
    n_checks++; if ({q, ser_out} !== {8'hFF, 1'b1})
      $display("FAIL shr10 got=%h_%b exp=ff_1", q, ser_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    op       = LOAD;
    amount   = 4'd0;
    data_in  = 8'h55;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({q, done} !== {8'h55, 1'b1}) $display("FAIL b2b_0 got=%h_%b exp=55_1", q, done); else n_pass++;
    op = INV;
    @(posedge clk);
    #1;
    n_checks++; if ({q, done} !== {8'hAA, 1'b1}) $display("FAIL b2b_1 got=%h_%b exp=aa_1", q, done); else n_pass++;
    op = NOP;
    @(posedge clk);
    #1;
    n_checks++; if ({q, done, busy} !== {8'hAA, 2'b10}) $display("FAIL b2b_2 got=%h_%b%b exp=aa_10", q, done, busy); else n_pass++;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL b2b_end got=%b exp=0", done); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    op       = NOP;
    amount   = '0;
    op_valid = 1'b0;
    data_in  = '0;
    ser_in   = 1'b0;
    test_reset();
    test_load();
    test_shl();
    test_asr_inv();
    test_ror_ignore();
    test_reset_mid_op();
    test_zero_amount();
    test_long_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
